// File: rtl/riscv_pkg.sv
// Shared core constants and types for the writeback path.
package riscv_pkg;

    localparam int unsigned RV_XLEN      = 32;
    localparam int unsigned RV_REG_AW    = 5;
    localparam int unsigned WB_AGE_W     = 2;
    localparam int unsigned WB_AGE_LIMIT = 3;

    typedef enum logic [1:0] {
        GntNone,
        GntAlu,
        GntLsu
    } wb_grant_e;

endpackage

// File: rtl/wb_age_counter.sv
// Saturating count of consecutive cycles the ALU writeback request has been stalled.
module wb_age_counter
    import riscv_pkg::*;
#(
    parameter int unsigned AGE_LIMIT = WB_AGE_LIMIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                alu_valid,
    input  logic                alu_ready,
    output logic [WB_AGE_W-1:0] age,
    output logic                age_sat
);

    localparam logic [WB_AGE_W-1:0] Limit = WB_AGE_W'(AGE_LIMIT);

    logic [WB_AGE_W-1:0] age_d, age_q;

    always_comb begin
        age_d = age_q;
        if (flush || !alu_valid || alu_ready) begin
            age_d = '0;
        end else if (age_q < Limit) begin
            age_d = age_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    assign age     = age_q;
    assign age_sat = (age_q >= Limit);

endmodule

// File: rtl/wb_arbiter.sv
// Two-requester register-file writeback arbiter: LSU first, ALU once it has aged out.
module wb_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN      = RV_XLEN,
    parameter int unsigned AGE_LIMIT = WB_AGE_LIMIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 alu_valid,
    input  logic [RV_REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]      alu_wd,
    output logic                 alu_ready,
    input  logic                 lsu_valid,
    input  logic [RV_REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]      lsu_wd,
    output logic                 lsu_ready,
    output logic                 rf_we,
    output logic [RV_REG_AW-1:0] rf_rd,
    output logic [XLEN-1:0]      rf_wd,
    output logic [WB_AGE_W-1:0]  alu_age
);

    wb_grant_e            grant;
    logic                 age_sat;
    logic                 rf_we_d, rf_we_q;
    logic [RV_REG_AW-1:0] rf_rd_d, rf_rd_q;
    logic [XLEN-1:0]      rf_wd_d, rf_wd_q;

    wb_age_counter #(
        .AGE_LIMIT (AGE_LIMIT)
    ) u_age (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .age       (alu_age),
        .age_sat   (age_sat)
    );

    always_comb begin
        grant = GntNone;
        if (!rst && !flush) begin
            if (alu_valid && (!lsu_valid || age_sat)) begin
                grant = GntAlu;
            end else if (lsu_valid) begin
                grant = GntLsu;
            end
        end
    end

    assign alu_ready = (grant == GntAlu);
    assign lsu_ready = (grant == GntLsu);

    // Address/data hold when idle; only the enable drops back to zero.
    always_comb begin
        rf_we_d = 1'b0;
        rf_rd_d = rf_rd_q;
        rf_wd_d = rf_wd_q;
        unique case (grant)
            GntAlu: begin
                rf_we_d = (alu_rd != '0);
                rf_rd_d = alu_rd;
                rf_wd_d = alu_wd;
            end
            GntLsu: begin
                rf_we_d = (lsu_rd != '0);
                rf_rd_d = lsu_rd;
                rf_wd_d = lsu_wd;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q <= 1'b0;
            rf_rd_q <= '0;
            rf_wd_q <= '0;
        end else begin
            rf_we_q <= rf_we_d;
            rf_rd_q <= rf_rd_d;
            rf_wd_q <= rf_wd_d;
        end
    end

    assign rf_we = rf_we_q;
    assign rf_rd = rf_rd_q;
    assign rf_wd = rf_wd_q;

endmodule
